// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Any block that talks to the shared memory bus imports these definitions.
package orion_types;

  localparam int ADDRW = 32;
  localparam int XLEN  = 32;
  localparam int MASKW = XLEN / 8;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and shared-bus signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int ADDRW = orion_types::ADDRW,
  parameter int XLEN  = orion_types::XLEN,
  parameter int MASKW = orion_types::MASKW
);

  logic             imem_valid_i;
  logic [ADDRW-1:0] imem_addr_i;
  logic             imem_ready_o;
  logic             imem_rvalid_o;
  logic [XLEN-1:0]  imem_rdata_o;

  logic             dmem_valid_i;
  logic [ADDRW-1:0] dmem_addr_i;
  logic [MASKW-1:0] dmem_mask_i;
  logic [XLEN-1:0]  dmem_wdata_i;
  logic             dmem_we_i;
  logic             dmem_ready_o;
  logic             dmem_rvalid_o;
  logic [XLEN-1:0]  dmem_rdata_o;

  logic             bus_req_o;
  logic [ADDRW-1:0] bus_addr_o;
  logic [MASKW-1:0] bus_mask_o;
  logic [XLEN-1:0]  bus_wdata_o;
  logic             bus_we_o;
  logic             bus_gnt_i;
  logic             bus_rvalid_i;
  logic [XLEN-1:0]  bus_rdata_i;

  modport slave (
    input  imem_valid_i, imem_addr_i,
    output imem_ready_o, imem_rvalid_o, imem_rdata_o,
    input  dmem_valid_i, dmem_addr_i, dmem_mask_i, dmem_wdata_i, dmem_we_i,
    output dmem_ready_o, dmem_rvalid_o, dmem_rdata_o,
    output bus_req_o, bus_addr_o, bus_mask_o, bus_wdata_o, bus_we_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport master (
    output imem_valid_i, imem_addr_i,
    input  imem_ready_o, imem_rvalid_o, imem_rdata_o,
    output dmem_valid_i, dmem_addr_i, dmem_mask_i, dmem_wdata_i, dmem_we_i,
    input  dmem_ready_o, dmem_rvalid_o, dmem_rdata_o,
    input  bus_req_o, bus_addr_o, bus_mask_o, bus_wdata_o, bus_we_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin decision with the last-grant history bit.
// The grant is combinational; history only advances when the bus takes a request.
module rr_arb2
  import orion_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic update,
  output gnt_t gnt
);

  gnt_t last_r;
  gnt_t gnt_s;

  // Pick the requester that was not served last when both are asking
  always_comb begin
    gnt_s = GNT_I;
    if (req_i && req_d) begin
      gnt_s = (last_r == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      gnt_s = GNT_D;
    end else begin
      gnt_s = GNT_I;
    end
  end

  assign gnt = gnt_s;

  // Remember who was served so the next conflict goes the other way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= GNT_I;
    end else if (update) begin
      last_r <= gnt_s;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one memory bus with a
// single outstanding transaction; the response is routed back with no added latency.
module mem_arbiter
  import orion_types::*;
#(
  parameter int ADDRW = orion_types::ADDRW,
  parameter int XLEN  = orion_types::XLEN,
  parameter int MASKW = orion_types::MASKW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_arbiter_if.slave      arb,
  output logic [15:0]       conflict_cnt_o,
  output logic              spurious_o
);

  arb_state_t       state_r;
  logic [15:0]      conflict_cnt_r;
  logic             spurious_r;

  gnt_t             win_s;
  logic             in_idle_s;
  logic             any_req_s;
  logic             both_req_s;
  logic             accept_s;

  logic             bus_req_s;
  logic [ADDRW-1:0] bus_addr_s;
  logic [MASKW-1:0] bus_mask_s;
  logic [XLEN-1:0]  bus_wdata_s;
  logic             bus_we_s;

  assign in_idle_s  = (state_r == IDLE);
  assign any_req_s  = arb.imem_valid_i | arb.dmem_valid_i;
  assign both_req_s = arb.imem_valid_i & arb.dmem_valid_i;
  // rst_i gates the handshake so nothing is granted while reset is held
  assign accept_s   = rst_i & in_idle_s & any_req_s & arb.bus_gnt_i;

  rr_arb2 u_rr_arb2 (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .req_i  (arb.imem_valid_i),
    .req_d  (arb.dmem_valid_i),
    .update (accept_s),
    .gnt    (win_s)
  );

  // Present the current winner's payload; fetches are full-word reads
  always_comb begin
    bus_addr_s  = arb.imem_addr_i;
    bus_mask_s  = {MASKW{1'b1}};
    bus_wdata_s = {XLEN{1'b0}};
    bus_we_s    = 1'b0;
    if (win_s == GNT_D) begin
      bus_addr_s  = arb.dmem_addr_i;
      bus_mask_s  = arb.dmem_mask_i;
      bus_wdata_s = arb.dmem_wdata_i;
      bus_we_s    = arb.dmem_we_i;
    end else begin
      bus_addr_s  = arb.imem_addr_i;
      bus_mask_s  = {MASKW{1'b1}};
      bus_wdata_s = {XLEN{1'b0}};
      bus_we_s    = 1'b0;
    end
    if (rst_i && in_idle_s) begin
      bus_req_s = any_req_s;
    end else begin
      bus_req_s = 1'b0;
    end
  end

  assign arb.bus_req_o   = bus_req_s;
  assign arb.bus_addr_o  = bus_addr_s;
  assign arb.bus_mask_o  = bus_mask_s;
  assign arb.bus_wdata_o = bus_wdata_s;
  assign arb.bus_we_o    = bus_we_s;

  assign arb.imem_ready_o  = accept_s & (win_s == GNT_I);
  assign arb.dmem_ready_o  = accept_s & (win_s == GNT_D);
  assign arb.imem_rvalid_o = rst_i & (state_r == WAIT_I) & arb.bus_rvalid_i;
  assign arb.dmem_rvalid_o = rst_i & (state_r == WAIT_D) & arb.bus_rvalid_i;
  assign arb.imem_rdata_o  = arb.bus_rdata_i;
  assign arb.dmem_rdata_o  = arb.bus_rdata_i;

  // Transaction FSM plus conflict counter and spurious-response flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r        <= IDLE;
      conflict_cnt_r <= 16'd0;
      spurious_r     <= 1'b0;
    end else begin
      spurious_r <= in_idle_s & arb.bus_rvalid_i;
      if (in_idle_s && both_req_s) begin
        conflict_cnt_r <= sat_inc16(conflict_cnt_r);
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= (win_s == GNT_D) ? WAIT_D : WAIT_I;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_I, WAIT_D: begin
          if (arb.bus_rvalid_i) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign conflict_cnt_o = conflict_cnt_r;
  assign spurious_o     = spurious_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected responses are queued at acceptance
// and popped when the DUT routes a response back.
module tb_mem_arbiter;
  import orion_types::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] conflict_cnt_o;
  logic        spurious_o;

  mem_arbiter_if #(.ADDRW(ADDRW), .XLEN(XLEN), .MASKW(MASKW)) bus_if ();

  mem_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .arb            (bus_if),
    .conflict_cnt_o (conflict_cnt_o),
    .spurious_o     (spurious_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic            port;
    logic            chk;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             e;
  int               vec_cnt = 0;
  int               err_cnt = 0;
  int               cnt_m   = 0;
  logic             last_m  = 1'b0;
  logic [ADDRW-1:0] resp_addr;

  function automatic logic [XLEN-1:0] mem_f(input logic [ADDRW-1:0] a);
    return XLEN'(a) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    bus_if.imem_valid_i = 1'b0;
    bus_if.imem_addr_i  = '0;
    bus_if.dmem_valid_i = 1'b0;
    bus_if.dmem_addr_i  = '0;
    bus_if.dmem_mask_i  = '0;
    bus_if.dmem_wdata_i = '0;
    bus_if.dmem_we_i    = 1'b0;
    bus_if.bus_gnt_i    = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    bus_if.bus_rdata_i  = '0;
  endtask

  task automatic apply_reset();
    clr_inputs();
    rst_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_i  = 1'b1;
    cnt_m  = 0;
    last_m = 1'b0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_i = 1'b0;
    bus_if.imem_valid_i = 1'b1;
    bus_if.dmem_valid_i = 1'b1;
    bus_if.bus_gnt_i    = 1'b1;
    bus_if.bus_rvalid_i = 1'b1;
    @(negedge clk_i);
    vec_cnt++;
    if ({bus_if.imem_ready_o, bus_if.dmem_ready_o} !== 2'b00) begin
      err_cnt++; $display("FAIL reset_ready: got %b want 00", {bus_if.imem_ready_o, bus_if.dmem_ready_o});
    end
    vec_cnt++;
    if ({bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o} !== 2'b00) begin
      err_cnt++; $display("FAIL reset_rvalid: got %b want 00", {bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o});
    end
    vec_cnt++;
    if (bus_if.bus_req_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_bus_req: got %b want 0", bus_if.bus_req_o);
    end
    vec_cnt++;
    if (conflict_cnt_o !== 16'd0 || spurious_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_status: got cnt %h spur %b want 0000 0", conflict_cnt_o, spurious_o);
    end
    next_cycle();
    clr_inputs();
    next_cycle();
    rst_i  = 1'b1;
    cnt_m  = 0;
    last_m = 1'b0;
  endtask

  task automatic test_fetch();
    bus_if.imem_valid_i = 1'b1;
    bus_if.imem_addr_i  = 32'h0000_0100;
    bus_if.bus_gnt_i    = 1'b1;
    @(negedge clk_i);
    vec_cnt++;
    if ({bus_if.imem_ready_o, bus_if.dmem_ready_o} !== 2'b10) begin
      err_cnt++; $display("FAIL fetch_ready: got %b want 10", {bus_if.imem_ready_o, bus_if.dmem_ready_o});
    end
    vec_cnt++;
    if ({bus_if.bus_req_o, bus_if.bus_addr_o, bus_if.bus_mask_o, bus_if.bus_wdata_o, bus_if.bus_we_o} !==
        {1'b1, 32'h0000_0100, 4'hF, 32'h0, 1'b0}) begin
      err_cnt++; $display("FAIL fetch_payload: got req %b addr %h mask %h wdata %h we %b want 1 100 f 0 0",
                          bus_if.bus_req_o, bus_if.bus_addr_o, bus_if.bus_mask_o, bus_if.bus_wdata_o, bus_if.bus_we_o);
    end
    sb_q.push_back('{port: 1'b0, chk: 1'b1, data: 32'hDEAD_BEEF});
    last_m = 1'b0;
    next_cycle();
    bus_if.imem_valid_i = 1'b0;
    bus_if.bus_gnt_i    = 1'b0;
    @(negedge clk_i);
    vec_cnt++;
    if ({bus_if.bus_req_o, bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o} !== 3'b000) begin
      err_cnt++; $display("FAIL fetch_wait: got req/irv/drv %b want 000",
                          {bus_if.bus_req_o, bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o});
    end
    next_cycle();
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    e = sb_q.pop_front();
    vec_cnt++;
    if ({bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o} !== 2'b10 || bus_if.imem_rdata_o !== e.data) begin
      err_cnt++; $display("FAIL fetch_resp: got rv %b data %h want 10 %h",
                          {bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o}, bus_if.imem_rdata_o, e.data);
    end
    next_cycle();
    clr_inputs();
  endtask

  task automatic test_alternate();
    logic w;
    apply_reset();
    bus_if.imem_valid_i = 1'b1;
    bus_if.imem_addr_i  = 32'h0000_0200;
    bus_if.dmem_valid_i = 1'b1;
    bus_if.dmem_addr_i  = 32'h0000_0300;
    bus_if.dmem_mask_i  = 4'hF;
    bus_if.bus_gnt_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = ~last_m;
      @(negedge clk_i);
      vec_cnt++;
      if ({bus_if.imem_ready_o, bus_if.dmem_ready_o} !== (w ? 2'b01 : 2'b10)) begin
        err_cnt++; $display("FAIL alt_grant%0d: got i/d ready %b want %b", k,
                            {bus_if.imem_ready_o, bus_if.dmem_ready_o}, (w ? 2'b01 : 2'b10));
      end
      vec_cnt++;
      if (bus_if.bus_addr_o !== (w ? 32'h0000_0300 : 32'h0000_0200)) begin
        err_cnt++; $display("FAIL alt_addr%0d: got %h want %h", k, bus_if.bus_addr_o,
                            (w ? 32'h0000_0300 : 32'h0000_0200));
      end
      sb_q.push_back('{port: w, chk: 1'b1, data: mem_f(w ? 32'h0000_0300 : 32'h0000_0200)});
      resp_addr = bus_if.bus_addr_o;
      last_m = w;
      next_cycle();
      cnt_m++;
      bus_if.bus_rvalid_i = 1'b1;
      bus_if.bus_rdata_i  = mem_f(resp_addr);
      @(negedge clk_i);
      e = sb_q.pop_front();
      vec_cnt++;
      if ({bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o} !== (e.port ? 2'b01 : 2'b10) ||
          (e.port ? bus_if.dmem_rdata_o : bus_if.imem_rdata_o) !== e.data) begin
        err_cnt++; $display("FAIL alt_resp%0d: got rv %b idata %h ddata %h want port %b data %h", k,
                            {bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o}, bus_if.imem_rdata_o,
                            bus_if.dmem_rdata_o, e.port, e.data);
      end
      vec_cnt++;
      if ({bus_if.imem_ready_o, bus_if.dmem_ready_o, bus_if.bus_req_o} !== 3'b000) begin
        err_cnt++; $display("FAIL alt_wait%0d: got ready/req %b want 000", k,
                            {bus_if.imem_ready_o, bus_if.dmem_ready_o, bus_if.bus_req_o});
      end
      next_cycle();
      bus_if.bus_rvalid_i = 1'b0;
    end
    @(negedge clk_i);
    vec_cnt++;
    if (conflict_cnt_o !== 16'd4) begin
      err_cnt++; $display("FAIL alt_conflicts: got %0d want 4 (model %0d)", conflict_cnt_o, cnt_m);
    end
    clr_inputs();
    next_cycle();
  endtask

  task automatic test_store_stall();
    logic exp_rdy;
    bus_if.dmem_valid_i = 1'b1;
    bus_if.dmem_addr_i  = 32'h0000_0040;
    bus_if.dmem_mask_i  = 4'b0011;
    bus_if.dmem_wdata_i = 32'h0000_1234;
    bus_if.dmem_we_i    = 1'b1;
    bus_if.bus_gnt_i    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_rdy = (k == 4);
      bus_if.bus_gnt_i = exp_rdy;
      @(negedge clk_i);
      vec_cnt++;
      if ({bus_if.bus_req_o, bus_if.bus_addr_o, bus_if.bus_mask_o, bus_if.bus_wdata_o, bus_if.bus_we_o} !==
          {1'b1, 32'h0000_0040, 4'b0011, 32'h0000_1234, 1'b1}) begin
        err_cnt++; $display("FAIL store_payload%0d: got req %b addr %h mask %b wdata %h we %b", k,
                            bus_if.bus_req_o, bus_if.bus_addr_o, bus_if.bus_mask_o, bus_if.bus_wdata_o, bus_if.bus_we_o);
      end
      vec_cnt++;
      if ({bus_if.imem_ready_o, bus_if.dmem_ready_o} !== {1'b0, exp_rdy}) begin
        err_cnt++; $display("FAIL store_ready%0d: got i/d %b want 0%b", k,
                            {bus_if.imem_ready_o, bus_if.dmem_ready_o}, exp_rdy);
      end
      if (exp_rdy) begin
        sb_q.push_back('{port: 1'b1, chk: 1'b0, data: 32'h0});
        last_m = 1'b1;
      end
      next_cycle();
    end
    bus_if.dmem_valid_i = 1'b0;
    bus_if.bus_gnt_i    = 1'b0;
    bus_if.bus_rvalid_i = 1'b1;
    @(negedge clk_i);
    e = sb_q.pop_front();
    vec_cnt++;
    if ({bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o} !== (e.port ? 2'b01 : 2'b10)) begin
      err_cnt++; $display("FAIL store_ack: got rv %b want port %b", {bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o}, e.port);
    end
    next_cycle();
    clr_inputs();
  endtask

  task automatic test_reset_mid();
    bus_if.dmem_valid_i = 1'b1;
    bus_if.dmem_addr_i  = 32'h0000_0080;
    bus_if.dmem_mask_i  = 4'hF;
    bus_if.bus_gnt_i    = 1'b1;
    @(negedge clk_i);
    vec_cnt++;
    if (bus_if.dmem_ready_o !== 1'b1) begin
      err_cnt++; $display("FAIL rmid_accept: got %b want 1", bus_if.dmem_ready_o);
    end
    next_cycle();
    clr_inputs();
    rst_i = 1'b0;
    @(negedge clk_i);
    vec_cnt++;
    if ({bus_if.dmem_rvalid_o, bus_if.bus_req_o} !== 2'b00) begin
      err_cnt++; $display("FAIL rmid_inreset: got rv/req %b want 00", {bus_if.dmem_rvalid_o, bus_if.bus_req_o});
    end
    next_cycle();
    rst_i  = 1'b1;
    cnt_m  = 0;
    last_m = 1'b0;
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk_i);
    vec_cnt++;
    if ({bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o} !== 2'b00) begin
      err_cnt++; $display("FAIL rmid_dropped: got rv %b want 00", {bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o});
    end
    next_cycle();
    bus_if.bus_rvalid_i = 1'b0;
    bus_if.imem_valid_i = 1'b1;
    bus_if.imem_addr_i  = 32'h0000_0140;
    bus_if.bus_gnt_i    = 1'b1;
    @(negedge clk_i);
    vec_cnt++;
    if (spurious_o !== 1'b1) begin
      err_cnt++; $display("FAIL rmid_spurious: got %b want 1", spurious_o);
    end
    vec_cnt++;
    if (bus_if.imem_ready_o !== 1'b1) begin
      err_cnt++; $display("FAIL rmid_idle: got imem_ready %b want 1", bus_if.imem_ready_o);
    end
    sb_q.push_back('{port: 1'b0, chk: 1'b1, data: mem_f(32'h0000_0140)});
    resp_addr = bus_if.bus_addr_o;
    next_cycle();
    bus_if.imem_addr_i  = 32'h0000_0180;
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i  = mem_f(resp_addr);
    @(negedge clk_i);
    e = sb_q.pop_front();
    vec_cnt++;
    if (bus_if.imem_rvalid_o !== 1'b1 || bus_if.imem_rdata_o !== e.data) begin
      err_cnt++; $display("FAIL overlap_resp: got rv %b data %h want 1 %h", bus_if.imem_rvalid_o, bus_if.imem_rdata_o, e.data);
    end
    vec_cnt++;
    if ({bus_if.imem_ready_o, spurious_o} !== 2'b00) begin
      err_cnt++; $display("FAIL overlap_noaccept: got ready/spur %b want 00", {bus_if.imem_ready_o, spurious_o});
    end
    next_cycle();
    bus_if.bus_rvalid_i = 1'b0;
    @(negedge clk_i);
    vec_cnt++;
    if (bus_if.imem_ready_o !== 1'b1 || bus_if.bus_addr_o !== 32'h0000_0180) begin
      err_cnt++; $display("FAIL overlap_next: got ready %b addr %h want 1 180", bus_if.imem_ready_o, bus_if.bus_addr_o);
    end
    sb_q.push_back('{port: 1'b0, chk: 1'b1, data: mem_f(32'h0000_0180)});
    resp_addr = bus_if.bus_addr_o;
    next_cycle();
    bus_if.imem_valid_i = 1'b0;
    bus_if.bus_rvalid_i = 1'b1;
    bus_if.bus_rdata_i  = mem_f(resp_addr);
    @(negedge clk_i);
    e = sb_q.pop_front();
    vec_cnt++;
    if ({bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o} !== 2'b10 || bus_if.imem_rdata_o !== e.data) begin
      err_cnt++; $display("FAIL overlap_resp2: got rv %b data %h want 10 %h",
                          {bus_if.imem_rvalid_o, bus_if.dmem_rvalid_o}, bus_if.imem_rdata_o, e.data);
    end
    next_cycle();
    clr_inputs();
  endtask

  task automatic test_saturate();
    bus_if.imem_valid_i = 1'b1;
    bus_if.imem_addr_i  = 32'h0000_0500;
    bus_if.dmem_valid_i = 1'b1;
    bus_if.dmem_addr_i  = 32'h0000_0600;
    bus_if.dmem_mask_i  = 4'hF;
    bus_if.bus_gnt_i    = 1'b0;
    @(negedge clk_i);
    vec_cnt++;
    if ({bus_if.bus_req_o, bus_if.imem_ready_o, bus_if.dmem_ready_o} !== 3'b100 ||
        bus_if.bus_addr_o !== (last_m ? 32'h0000_0500 : 32'h0000_0600)) begin
      err_cnt++; $display("FAIL stall_winner: got req/ready %b addr %h want 100 %h",
                          {bus_if.bus_req_o, bus_if.imem_ready_o, bus_if.dmem_ready_o}, bus_if.bus_addr_o,
                          (last_m ? 32'h0000_0500 : 32'h0000_0600));
    end
    while (cnt_m < 32'h0000_FFFE) begin
      next_cycle();
      cnt_m++;
    end
    @(negedge clk_i);
    vec_cnt++;
    if (conflict_cnt_o !== 16'hFFFE) begin
      err_cnt++; $display("FAIL sat_preload: got %h want fffe", conflict_cnt_o);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      if (cnt_m < 65535) cnt_m++;
      @(negedge clk_i);
      vec_cnt++;
      if (conflict_cnt_o !== 16'(cnt_m) || conflict_cnt_o !== 16'hFFFF) begin
        err_cnt++; $display("FAIL sat_step%0d: got %h want ffff", k, conflict_cnt_o);
      end
    end
    clr_inputs();
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_inputs();
    rst_i = 1'b0;
    next_cycle();
    test_reset();
    test_fetch();
    test_alternate();
    test_store_stall();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
